markov_melody_generator: RTL and testbench
==========================================

Name: markov_melody_generator

Overview:
Downstream consumer of the second Markov merge stage. On start (driven by the merge-2 done), it walks the merged packed Markov chain table as a weighted random process and streams a generated melody of note/delay pairs over a valid/ready handshake. Randomness comes from an internal 16-bit LFSR with an externally supplied seed.

Parameters:
NOTE_BIT_LEN, 5, bits per note code
DELAY_BIT_LEN, 3, bits per delay code
SEQUENCE_LEN, 2, note/delay pairs per chain entry (context = pairs 0..SEQUENCE_LEN-2, successor = pair SEQUENCE_LEN-1)
SEQ_CNT_BIT_LEN, 4, occurrence-count bits per entry
CHAIN_ENTRIES, 16, entries in merged table (4*MARKOV_CHAIN_LEN)
OUT_NOTES, 32, notes generated per run

Ports:
clk  in  1  clock, all logic rising-edge
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle run request (tie to merge-2 done rising edge)
seed  in  16  LFSR seed, sampled on accepted start
markov  in  CHAIN_ENTRIES*E  packed table, E = SEQUENCE_LEN*(NOTE_BIT_LEN+DELAY_BIT_LEN)+SEQ_CNT_BIT_LEN; must be stable while busy
note_out  out  NOTE_BIT_LEN  generated note
delay_out  out  DELAY_BIT_LEN  generated delay
note_valid  out  1  note_out/delay_out valid
note_ready  in  1  downstream accepts
busy  out  1  run in progress
done  out  1  run finished; held until next accepted start
error  out  1  table had no nonzero-count entry; valid while done=1

Behaviour:
- Packing: entry i = markov[(i+1)*E-1 : i*E]; count = entry low SEQ_CNT_BIT_LEN bits; pair j at offset SEQ_CNT_BIT_LEN + j*(NOTE+DELAY); within a pair, delay is the low bits and note the high bits.
- Reset (reset=0, async): state IDLE; note_out, delay_out, note_valid, busy, done, error = 0; LFSR = 16'hACE1; context and counters = 0. Reset mid-run aborts immediately with no further handshake.
- IDLE: start=1 -> latch LFSR = seed (seed==0 -> 16'hACE1), clear done/error, busy=1, go to SEED. start while busy is ignored.
- SEED: scan entries 0..CHAIN_ENTRIES-1, one per cycle; the first entry with count!=0 becomes the seed entry (index stored), context := its context pairs, go to SUM. No hit -> DONE with error=1, zero notes emitted.
- SUM: CHAIN_ENTRIES cycles; total += count for every entry whose context equals the current context and count!=0. Total width = SEQ_CNT_BIT_LEN+clog2(CHAIN_ENTRIES), no overflow possible. Total==0 (dead end) -> context := seed entry context and restart SUM (guaranteed nonzero).
- TARGET: 1 cycle; target = (LFSR[7:0] * total) >> 8, range 0..total-1.
- PICK: scan from entry 0 one per cycle, accumulating run over matching entries; select the first matching entry where run+count > target; then go to EMIT. Scan length at most CHAIN_ENTRIES.
- EMIT: note_out/delay_out = selected successor pair, note_valid=1. Outputs are held stable while note_ready=0. On note_valid&&note_ready: note_valid=0 next cycle; context shifts left one pair with the successor appended; LFSR advances one step (x^16+x^14+x^13+x^11+1, Fibonacci, shift toward MSB); emitted count +1; count==OUT_NOTES -> DONE, else SUM.
- LFSR changes only on a seed load or an EMIT handshake.
- DONE: busy=0, done=1, note_valid=0; start -> restarts as from IDLE.
- Per-note latency from SUM entry to note_valid: CHAIN_ENTRIES + 1 + (picked index+1) cycles. Add CHAIN_ENTRIES cycles for each dead-end reseed.

Test Plan:
- Single entry 0: context (note 12, delay 2) -> successor (12,2), count 5, others 0; start, note_ready=1 -> exactly 32 handshakes, all note 12/delay 2; then done=1, busy=0, error=0.
- Dead end: entry 0 (1,1)->(2,1), count 3, others 0 -> 32 notes, all note 2/delay 1 (reseed after every note); done=1.
- All counts 0 -> done=1, error=1 within CHAIN_ENTRIES+2 cycles of start; note_valid never asserted.
- Backpressure: hold note_ready=0 for 10 cycles on the first note -> note_valid stays 1, note_out/delay_out stable, LFSR unchanged; release -> one handshake, run continues.
- Weighting: entries (1,1)->(3,1) count 1 and (1,1)->(4,1) count 15; seed 16'h1234; run repeated 8 times (256 notes) -> all notes 3 or 4, note 3 count between 4 and 40; the same seed reproduces an identical sequence.
- Reset pulse mid-EMIT -> all outputs 0 immediately, busy=0; a later start runs a full 32-note run normally.

Source files
------------

// File: rtl/markov_melody_generator_if.sv
// Note/delay stream handshake between the melody generator and its consumer.
// The master drives the pair and valid; the slave answers with ready.
interface markov_melody_generator_if #(
    parameter int NOTE_BIT_LEN  = 5,
    parameter int DELAY_BIT_LEN = 3
);
    logic [NOTE_BIT_LEN-1:0]  note_out;
    logic [DELAY_BIT_LEN-1:0] delay_out;
    logic                     note_valid;
    logic                     note_ready;

    modport master (
        output note_out,
        output delay_out,
        output note_valid,
        input  note_ready
    );

    modport slave (
        input  note_out,
        input  delay_out,
        input  note_valid,
        output note_ready
    );
endinterface

// File: rtl/markov_melody_generator.sv
// Walks a packed Markov chain table as a weighted random process and
// streams the generated note/delay pairs out over a valid/ready handshake.
module markov_melody_generator #(
    parameter int NOTE_BIT_LEN    = 5,
    parameter int DELAY_BIT_LEN   = 3,
    parameter int SEQUENCE_LEN    = 2,
    parameter int SEQ_CNT_BIT_LEN = 4,
    parameter int CHAIN_ENTRIES   = 16,
    parameter int OUT_NOTES       = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] seed,
    input  logic [CHAIN_ENTRIES*(SEQUENCE_LEN*(NOTE_BIT_LEN+DELAY_BIT_LEN)
                  +SEQ_CNT_BIT_LEN)-1:0] markov,
    markov_melody_generator_if.master mel,
    output logic        busy,
    output logic        done,
    output logic        error
);
    localparam int PAIR_W = NOTE_BIT_LEN + DELAY_BIT_LEN;
    localparam int CTX_W  = (SEQUENCE_LEN - 1) * PAIR_W;
    localparam int CNT_W  = SEQ_CNT_BIT_LEN;
    localparam int E      = SEQUENCE_LEN * PAIR_W + CNT_W;
    localparam int IDX_W  = $clog2(CHAIN_ENTRIES);
    localparam int TOT_W  = CNT_W + IDX_W;
    localparam int OUT_W  = $clog2(OUT_NOTES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEED, S_SUM, S_TARGET, S_PICK, S_EMIT, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [15:0]       lfsr;
    logic [IDX_W-1:0]  idx;
    logic [CTX_W-1:0]  ctx;
    logic [CTX_W-1:0]  seed_ctx;
    logic [TOT_W-1:0]  total;
    logic [TOT_W-1:0]  target;
    logic [TOT_W-1:0]  run;
    logic [PAIR_W-1:0] sel;
    logic [OUT_W-1:0]  emitted;

    logic [E-1:0]        entry;
    logic [CNT_W-1:0]    cnt;
    logic [CTX_W-1:0]    ectx;
    logic [PAIR_W-1:0]   esucc;
    logic                hit;
    logic                last;
    logic [TOT_W-1:0]    total_acc;
    logic [TOT_W-1:0]    run_acc;
    logic                pick_hit;
    logic [15:0]         lfsr_step;
    logic [8+TOT_W-1:0]  prod;
    logic [CTX_W-1:0]    ctx_next;
    logic                start_ok;
    logic                last_note;

    assign entry     = markov[idx*E +: E];
    assign cnt       = entry[CNT_W-1:0];
    assign ectx      = entry[CNT_W +: CTX_W];
    assign esucc     = entry[CNT_W+CTX_W +: PAIR_W];
    assign hit       = (ectx == ctx) && (cnt != '0);
    assign last      = (idx == IDX_W'(CHAIN_ENTRIES - 1));
    assign total_acc = total + (hit ? TOT_W'(cnt) : '0);
    assign run_acc   = run + TOT_W'(cnt);
    assign pick_hit  = hit && (run_acc > target);
    assign lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    // target = (lfsr[7:0] * total) >> 8 lands in 0..total-1
    assign prod      = {{TOT_W{1'b0}}, lfsr[7:0]} * {8'd0, total};
    assign ctx_next  = (ctx >> PAIR_W) | (CTX_W'(sel) << (CTX_W - PAIR_W));
    assign start_ok  = start && (state == S_IDLE || state == S_DONE);
    assign last_note = (emitted == OUT_W'(OUT_NOTES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE: if (start_ok) state_nxt = S_SEED;
            S_SEED: begin
                if (cnt != '0) state_nxt = S_SUM;
                else if (last) state_nxt = S_DONE;
            end
            S_SUM:    if (last && total_acc != '0) state_nxt = S_TARGET;
            S_TARGET: state_nxt = S_PICK;
            S_PICK:   if (pick_hit) state_nxt = S_EMIT;
            S_EMIT: begin
                if (mel.note_ready) state_nxt = last_note ? S_DONE : S_SUM;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mel.note_valid = (state == S_EMIT);
        mel.note_out   = '0;
        mel.delay_out  = '0;
        if (state == S_EMIT) begin
            mel.note_out  = sel[PAIR_W-1:DELAY_BIT_LEN];
            mel.delay_out = sel[DELAY_BIT_LEN-1:0];
        end
        busy = (state != S_IDLE) && (state != S_DONE);
        done = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr     <= 16'hACE1;
            idx      <= '0;
            ctx      <= '0;
            seed_ctx <= '0;
            total    <= '0;
            target   <= '0;
            run      <= '0;
            sel      <= '0;
            emitted  <= '0;
            error    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        lfsr    <= (seed == 16'h0) ? 16'hACE1 : seed;
                        error   <= 1'b0;
                        idx     <= '0;
                        emitted <= '0;
                    end
                end
                S_SEED: begin
                    if (cnt != '0) begin
                        seed_ctx <= ectx;
                        ctx      <= ectx;
                        idx      <= '0;
                        total    <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                        if (last) error <= 1'b1;
                    end
                end
                S_SUM: begin
                    if (last) begin
                        idx <= '0;
                        // dead end: fall back to the seed context and resum
                        if (total_acc == '0) begin
                            ctx   <= seed_ctx;
                            total <= '0;
                        end else begin
                            total <= total_acc;
                        end
                    end else begin
                        idx   <= idx + 1'b1;
                        total <= total_acc;
                    end
                end
                S_TARGET: begin
                    target <= prod[8 +: TOT_W];
                    run    <= '0;
                    idx    <= '0;
                end
                S_PICK: begin
                    if (pick_hit) begin
                        sel <= esucc;
                    end else begin
                        if (hit) run <= run_acc;
                        idx <= idx + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (mel.note_ready) begin
                        ctx     <= ctx_next;
                        lfsr    <= lfsr_step;
                        emitted <= emitted + 1'b1;
                        idx     <= '0;
                        total   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_markov_melody_generator.sv
// Directed bench for the Markov melody generator: single chain, dead end,
// empty table, backpressure, weighting/reproducibility and mid-run reset.
module tb_markov_melody_generator;
    localparam int CH = 16;
    localparam int E  = 20;
    localparam int MW = CH * E;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [15:0]   seed;
    logic [MW-1:0] markov;
    logic          busy;
    logic          done;
    logic          error;

    int passed = 0;
    int total  = 0;

    logic [7:0] got_q[$];

    markov_melody_generator_if #(.NOTE_BIT_LEN(5), .DELAY_BIT_LEN(3)) mel();

    markov_melody_generator dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .seed(seed),
        .markov(markov),
        .mel(mel.master),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] mk_entry(
        input logic [4:0] n0, input logic [2:0] d0,
        input logic [4:0] n1, input logic [2:0] d1,
        input logic [3:0] c);
        return {n1, d1, n0, d0, c};
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    task automatic pulse_start(input logic [15:0] s);
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic collect(input int bound, output int got, output logic fin);
        got = 0;
        fin = 1'b0;
        got_q.delete();
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (mel.note_valid && mel.note_ready) begin
                got_q.push_back({mel.note_out, mel.delay_out});
                got++;
            end
            if (done) begin
                fin = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_valid(input int bound, output int cyc);
        cyc = 0;
        while (!mel.note_valid && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b0;
        seed  = 16'h0;
        markov = '0;
        mel.note_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({mel.note_valid, busy, done, error} !== 4'b0) begin
            $display("FAIL reset_flags got=%b want=0000",
                     {mel.note_valid, busy, done, error});
        end else passed++;
        total++;
        if ({mel.note_out, mel.delay_out} !== 8'h00) begin
            $display("FAIL reset_pair got=%h want=00",
                     {mel.note_out, mel.delay_out});
        end else passed++;
        total++;
        if (dut.lfsr !== 16'hACE1) begin
            $display("FAIL reset_lfsr got=%h want=ace1", dut.lfsr);
        end else passed++;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done} !== 2'b00) begin
            $display("FAIL idle_after_reset got=%b want=00", {busy, done});
        end else passed++;
    endtask

    task automatic test_single;
        int cyc, got, bad;
        logic fin;
        markov = '0;
        markov[0 +: E] = mk_entry(5'd12, 3'd2, 5'd12, 3'd2, 4'd5);
        mel.note_ready = 1'b1;
        @(negedge clk);
        seed  = 16'h0001;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (!mel.note_valid && cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
        end
        total++;
        if (cyc !== 19) begin
            $display("FAIL first_latency got=%0d want=19", cyc);
        end else passed++;
        collect(3000, got, fin);
        total++;
        if (got !== 32) begin
            $display("FAIL single_count got=%0d want=32", got);
        end else passed++;
        bad = 0;
        foreach (got_q[i]) if (got_q[i] !== {5'd12, 3'd2}) bad++;
        total++;
        if (bad !== 0) begin
            $display("FAIL single_notes got=%0d bad want=0", bad);
        end else passed++;
        total++;
        if ({fin, done, busy, error} !== 4'b1100) begin
            $display("FAIL single_end got=%b want=1100",
                     {fin, done, busy, error});
        end else passed++;
        repeat (5) @(negedge clk);
        total++;
        if ({mel.note_valid, done} !== 2'b01) begin
            $display("FAIL single_quiet got=%b want=01",
                     {mel.note_valid, done});
        end else passed++;
    endtask

    task automatic test_dead_end;
        int got, bad;
        logic fin;
        markov = '0;
        markov[0 +: E] = mk_entry(5'd1, 3'd1, 5'd2, 3'd1, 4'd3);
        mel.note_ready = 1'b1;
        pulse_start(16'h0BEE);
        collect(3000, got, fin);
        total++;
        if (got !== 32) begin
            $display("FAIL dead_count got=%0d want=32", got);
        end else passed++;
        bad = 0;
        foreach (got_q[i]) if (got_q[i] !== {5'd2, 3'd1}) bad++;
        total++;
        if (bad !== 0) begin
            $display("FAIL dead_notes got=%0d bad want=0", bad);
        end else passed++;
        total++;
        if ({fin, done, error} !== 3'b110) begin
            $display("FAIL dead_end got=%b want=110", {fin, done, error});
        end else passed++;
    endtask

    task automatic test_all_zero;
        logic seen;
        markov = '0;
        mel.note_ready = 1'b1;
        seen = 1'b0;
        pulse_start(16'h5555);
        for (int c = 0; c < CH + 2; c++) begin
            @(negedge clk);
            if (mel.note_valid) seen = 1'b1;
            if (done) break;
        end
        total++;
        if ({done, error, busy} !== 3'b110) begin
            $display("FAIL zero_end got=%b want=110", {done, error, busy});
        end else passed++;
        total++;
        if (seen !== 1'b0) begin
            $display("FAIL zero_valid got=%b want=0", seen);
        end else passed++;
    endtask

    task automatic test_backpressure;
        int cyc, got, bad;
        logic fin;
        logic [7:0] held;
        markov = '0;
        markov[0 +: E] = mk_entry(5'd12, 3'd2, 5'd12, 3'd2, 4'd5);
        mel.note_ready = 1'b0;
        pulse_start(16'h1234);
        wait_valid(100, cyc);
        total++;
        if (cyc >= 100) begin
            $display("FAIL bp_wait got=timeout want=valid");
        end else passed++;
        held = {mel.note_out, mel.delay_out};
        total++;
        if (held !== {5'd12, 3'd2}) begin
            $display("FAIL bp_pair got=%h want=%h", held, {5'd12, 3'd2});
        end else passed++;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!mel.note_valid || {mel.note_out, mel.delay_out} !== held)
                bad++;
        end
        total++;
        if (bad !== 0) begin
            $display("FAIL bp_hold got=%0d unstable want=0", bad);
        end else passed++;
        total++;
        if (dut.lfsr !== 16'h1234) begin
            $display("FAIL bp_lfsr got=%h want=1234", dut.lfsr);
        end else passed++;
        mel.note_ready = 1'b1;
        @(negedge clk);
        total++;
        if (mel.note_valid !== 1'b0) begin
            $display("FAIL bp_release got=%b want=0", mel.note_valid);
        end else passed++;
        total++;
        if (dut.lfsr !== lfsr_next(16'h1234)) begin
            $display("FAIL bp_lfsr_step got=%h want=%h",
                     dut.lfsr, lfsr_next(16'h1234));
        end else passed++;
        collect(3000, got, fin);
        total++;
        if ({got, fin} !== {32'd31, 1'b1}) begin
            $display("FAIL bp_rest got=%0d/%b want=31/1", got, fin);
        end else passed++;
    endtask

    task automatic test_weighting;
        int got, t, n3, bad, reps;
        logic fin;
        logic [15:0] m;
        logic [4:0] exp_note;
        logic [7:0] first[32];
        markov = '0;
        markov[0 +: E]     = mk_entry(5'd1, 3'd1, 5'd3, 3'd1, 4'd1);
        markov[E +: E]     = mk_entry(5'd1, 3'd1, 5'd4, 3'd1, 4'd15);
        mel.note_ready = 1'b1;
        m = 16'h1234;
        n3 = 0;
        for (int r = 0; r < 8; r++) begin
            pulse_start(m);
            collect(3000, got, fin);
            total++;
            if ({got, fin} !== {32'd32, 1'b1}) begin
                $display("FAIL weight_run%0d got=%0d/%b want=32/1", r, got, fin);
            end else passed++;
            bad = 0;
            for (int i = 0; i < 32; i++) begin
                t = (int'(m[7:0]) * 16) >> 8;
                exp_note = (t < 1) ? 5'd3 : 5'd4;
                if (r == 0) first[i] = {exp_note, 3'd1};
                if (i < got) begin
                    if (got_q[i] !== {exp_note, 3'd1}) bad++;
                    if (got_q[i][7:3] == 5'd3) n3++;
                end
                m = lfsr_next(m);
            end
            total++;
            if (bad !== 0) begin
                $display("FAIL weight_seq%0d got=%0d bad want=0", r, bad);
            end else passed++;
        end
        total++;
        if ((n3 >= 4 && n3 <= 40) !== 1'b1) begin
            $display("FAIL weight_ratio got=%0d want=4..40", n3);
        end else passed++;
        pulse_start(16'h1234);
        collect(3000, got, fin);
        reps = 0;
        for (int i = 0; i < 32; i++)
            if (i < got && got_q[i] === first[i]) reps++;
        total++;
        if (reps !== 32) begin
            $display("FAIL weight_repeat got=%0d want=32", reps);
        end else passed++;
    endtask

    task automatic test_reset_mid;
        int cyc, got, bad;
        logic fin;
        markov = '0;
        markov[0 +: E] = mk_entry(5'd12, 3'd2, 5'd12, 3'd2, 4'd5);
        mel.note_ready = 1'b0;
        pulse_start(16'h00FF);
        wait_valid(100, cyc);
        total++;
        if (mel.note_valid !== 1'b1) begin
            $display("FAIL mid_wait got=%b want=1", mel.note_valid);
        end else passed++;
        #2 reset = 1'b0;
        #1;
        total++;
        if ({mel.note_valid, busy, done, error} !== 4'b0) begin
            $display("FAIL mid_reset_flags got=%b want=0000",
                     {mel.note_valid, busy, done, error});
        end else passed++;
        total++;
        if ({mel.note_out, mel.delay_out} !== 8'h00) begin
            $display("FAIL mid_reset_pair got=%h want=00",
                     {mel.note_out, mel.delay_out});
        end else passed++;
        @(negedge clk);
        reset = 1'b1;
        mel.note_ready = 1'b1;
        pulse_start(16'h00FF);
        collect(3000, got, fin);
        bad = 0;
        foreach (got_q[i]) if (got_q[i] !== {5'd12, 3'd2}) bad++;
        total++;
        if ({got, fin, bad} !== {32'd32, 1'b1, 32'd0}) begin
            $display("FAIL mid_rerun got=%0d/%b/%0d want=32/1/0",
                     got, fin, bad);
        end else passed++;
    endtask

    initial begin
        test_reset;
        test_single;
        test_dead_end;
        test_all_zero;
        test_backpressure;
        test_weighting;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
